pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Stall/flush sequencer for a linear chain of pipeline registers built from enable/clear flops. Each cycle it resolves per-stage stall requests, flush requests and one multicycle-operation hold into an `en`/`clear` pair per register, and tracks a valid bit per stage. It sits beside the datapath: `en[i]`/`clear[i]` drive the `en`/`clear` pins of every flop in pipeline register i. A clear only takes effect when `en` is high, so the block never asserts `clear[i]` without `en[i]`.

## Interface
- `NSTAGES`, 5: number of pipeline registers. Index 0 is youngest (fetch side); index NSTAGES-1 is oldest.
- `MCSTAGE`, 2: stage that hosts multicycle operations; 0 ≤ MCSTAGE < NSTAGES.
- `CNTW`, 6: width of the multicycle cycle count.
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `fetch_valid` in 1: a valid instruction is presented at the input of register 0.
- `stall_req` in NSTAGES: stage i cannot advance this cycle.
- `flush_req` in NSTAGES: stage i kills every stage younger than i (0..i-1). Stage i itself survives.
- `mc_start` in 1: the stage-MCSTAGE instruction begins a multicycle operation.
- `mc_cycles` in CNTW: total hold cycles for that operation, sampled with `mc_start`.
- `en` out NSTAGES: load enable per register.
- `clear` out NSTAGES: clear per register (bubble insertion).
- `valid` out NSTAGES: register i holds a valid instruction.
- `mc_busy` out 1: multicycle countdown active (cnt ≠ 0).
- `mc_done` out 1: one-cycle registered completion pulse.

## Operation
Definitions, evaluated combinationally:
- `kill_self[i]` = OR of `flush_req[j]` for j>i.
- `mc_accept` = `mc_start` & `valid[MCSTAGE]` & ~`mc_busy` & ~`kill_self[MCSTAGE]` & (`mc_cycles` ≠ 0).
- `mc_hold` = `mc_busy` | `mc_accept`.
- `hold[i]` = (OR of `stall_req[j]` for j≥i) | (`mc_hold` & i≤MCSTAGE).
- `in_valid[i]` = `fetch_valid` for i=0; otherwise `valid[i-1]`.

Per-register decision, in priority order:
1. `kill_self[i]` -> en=1, clear=1. Flush overrides stall.
2. `hold[i]` -> en=0, clear=0.
3. Incoming slot is a bubble -> en=1, clear=1. The incoming slot is a bubble when `flush_req[i]`, or i>0 with stage i-1 held, or i=0 with ~`fetch_valid`.
4. Otherwise -> en=1, clear=0; register i loads stage i-1.

Other rules:
- `valid[i]` next state: en&clear -> 0; en&~clear -> `in_valid[i]`; ~en -> hold.
- Multicycle counter `cnt` (CNTW bits):
  - On `mc_accept`, load `mc_cycles`-1.
  - While `cnt` ≠ 0, decrement by 1 each cycle.
  - `mc_start` while `mc_busy` is ignored.
  - `mc_cycles`=0 is ignored: no hold, no pulse.
- `mc_done` is set the cycle after the last hold cycle (`mc_hold` high, next `cnt`=0, no abort). It stays high for one cycle only.
- Abort: if `kill_self[MCSTAGE]` is high while `mc_busy`, clear `cnt` to 0. No `mc_done` is produced.

## Timing
- Reset (`reset_n` low, asynchronous):
  - `valid`=0, `cnt`=0, `mc_busy`=0, `mc_done`=0 immediately.
  - While `reset_n` is low, `en` and `clear` are forced to all ones so every datapath register clears.
  - First normal decision is on the first clock edge after release.
- `en`, `clear` and `mc_accept` are combinational from the inputs, with zero latency. `valid`, `cnt` and `mc_done` are registered.
- Stall propagates from older to younger in the same cycle. The first non-held stage older than a held stage receives a bubble.
- A multicycle operation holds stages 0..MCSTAGE for exactly `mc_cycles` cycles, counting the accept cycle. `mc_done` rises on the following cycle.
- Simultaneous flush and stall on the same register: flush wins.
- Simultaneous flushes: the oldest requester defines the killed range.
- Reset mid-operation discards the countdown and all valid bits.

## Test plan
All scenarios use NSTAGES=5, MCSTAGE=2. Vectors are written MSB=stage 4.
- **Fill:** after reset, `fetch_valid`=1 for 5 cycles -> `valid` steps 00001, 00011, 00111, 01111, 11111; `en`=11111, `clear`=00000 every cycle.
- **Stall:** full pipe, `stall_req`=01000 for 1 cycle -> `en`=10000, `clear`=10000; next `valid`=01111, then refills.
- **Flush vs stall:** full pipe, `flush_req`=01000 with `stall_req`=00010 -> `en`=11111, `clear`=01111; next `valid`=10000.
- **Multicycle:** full pipe, `mc_start`=1 with `mc_cycles`=3:
  - Accept cycle: `en`=11000, `clear`=01000.
  - Two further cycles: `en`=11000 with `mc_busy`=1.
  - 4th cycle: `mc_done`=1, `en`=11111.
  - A repeat with `mc_cycles`=0 produces no hold.
- **Abort:** `mc_cycles`=10, then `flush_req`=01000 on the 2nd busy cycle -> `clear`=01111 that cycle; `mc_busy`=0 on the next cycle; `mc_done` never pulses.
- **Async reset:** drop `reset_n` mid-multicycle, between clock edges -> `valid`=0, `mc_busy`=0, `en`=`clear`=11111 without waiting for an edge; normal refill after release.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a linear chain of enable/clear pipeline registers.
// Resolves stall, flush and multicycle hold into per-register en/clear and tracks stage valids.
module pipe_hazard_ctrl #(
  parameter int unsigned NSTAGES = 5,
  parameter int unsigned MCSTAGE = 2,
  parameter int unsigned CNTW    = 6
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               fetch_valid_i,
  input  logic [NSTAGES-1:0] stall_req_i,
  input  logic [NSTAGES-1:0] flush_req_i,
  input  logic               mc_start_i,
  input  logic [CNTW-1:0]    mc_cycles_i,
  output logic [NSTAGES-1:0] en_o,
  output logic [NSTAGES-1:0] clear_o,
  output logic [NSTAGES-1:0] valid_o,
  output logic               mc_busy_o,
  output logic               mc_done_o
);

  logic [NSTAGES-1:0] valid_q, valid_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic               mc_done_q, mc_done_d;

  logic [NSTAGES-1:0] kill_self, stall_or, hold, bubble_in, in_valid;
  logic [NSTAGES-1:0] en, clear;
  logic               mc_busy, mc_accept, mc_hold, mc_abort;

  assign mc_busy   = (cnt_q != '0);
  assign in_valid  = {valid_q[NSTAGES-2:0], fetch_valid_i};

  always_comb begin
    kill_self = '0;
    stall_or  = '0;
    for (int unsigned i = 0; i < NSTAGES; i++) begin
      kill_self[i] = |(flush_req_i >> (i + 1));
      stall_or[i]  = |(stall_req_i >> i);
    end
  end

  assign mc_accept = mc_start_i & valid_q[MCSTAGE] & ~mc_busy & ~kill_self[MCSTAGE] &
                     (mc_cycles_i != '0);
  assign mc_hold   = mc_busy | mc_accept;
  assign mc_abort  = mc_busy & kill_self[MCSTAGE];

  always_comb begin
    hold = '0;
    for (int unsigned i = 0; i < NSTAGES; i++) begin
      hold[i] = stall_or[i] | (mc_hold & (i <= MCSTAGE));
    end
  end

  // A register receives a bubble when its own slot is flushed or its feeder is held.
  assign bubble_in = flush_req_i | {hold[NSTAGES-2:0], ~fetch_valid_i};

  always_comb begin
    en      = '0;
    clear   = '0;
    valid_d = valid_q;
    for (int unsigned i = 0; i < NSTAGES; i++) begin
      if (kill_self[i]) begin
        en[i]    = 1'b1;
        clear[i] = 1'b1;
      end else if (hold[i]) begin
        en[i]    = 1'b0;
        clear[i] = 1'b0;
      end else if (bubble_in[i]) begin
        en[i]    = 1'b1;
        clear[i] = 1'b1;
      end else begin
        en[i]    = 1'b1;
        clear[i] = 1'b0;
      end
      if (en[i]) begin
        valid_d[i] = clear[i] ? 1'b0 : in_valid[i];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (mc_abort) begin
      cnt_d = '0;
    end else if (mc_accept) begin
      cnt_d = mc_cycles_i - CNTW'(1);
    end else if (mc_busy) begin
      cnt_d = cnt_q - CNTW'(1);
    end
    mc_done_d = mc_hold & (cnt_d == '0) & ~mc_abort;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q   <= '0;
      cnt_q     <= '0;
      mc_done_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
      mc_done_q <= mc_done_d;
    end
  end

  // While in reset every datapath register is cleared.
  assign en_o      = rst_ni ? en : '1;
  assign clear_o   = rst_ni ? clear : '1;
  assign valid_o   = valid_q;
  assign mc_busy_o = mc_busy;
  assign mc_done_o = mc_done_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl with NSTAGES=5, MCSTAGE=2.
module tb_pipe_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       fetch_valid_i;
  logic [4:0] stall_req_i;
  logic [4:0] flush_req_i;
  logic       mc_start_i;
  logic [5:0] mc_cycles_i;
  logic [4:0] en_o, clear_o, valid_o;
  logic       mc_busy_o, mc_done_o;

  int checks   = 0;
  int failures = 0;

  pipe_hazard_ctrl #(
    .NSTAGES(5),
    .MCSTAGE(2),
    .CNTW   (6)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .fetch_valid_i(fetch_valid_i),
    .stall_req_i  (stall_req_i),
    .flush_req_i  (flush_req_i),
    .mc_start_i   (mc_start_i),
    .mc_cycles_i  (mc_cycles_i),
    .en_o         (en_o),
    .clear_o      (clear_o),
    .valid_o      (valid_o),
    .mc_busy_o    (mc_busy_o),
    .mc_done_o    (mc_done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni        = 1'b0;
    fetch_valid_i = 1'b0;
    stall_req_i   = '0;
    flush_req_i   = '0;
    mc_start_i    = 1'b0;
    mc_cycles_i   = '0;
    #1;
    chk("rst_valid", 32'(valid_o), 32'h00);
    chk("rst_en", 32'(en_o), 32'h1f);
    chk("rst_clear", 32'(clear_o), 32'h1f);
    chk("rst_busy", 32'(mc_busy_o), 32'h0);
    chk("rst_done", 32'(mc_done_o), 32'h0);

    // Fill
    #11;
    rst_ni        = 1'b1;
    fetch_valid_i = 1'b1;
    #1;
    chk("fill_en0", 32'(en_o), 32'h1f);
    chk("fill_clear0", 32'(clear_o), 32'h00);
    for (int k = 1; k <= 5; k++) begin
      tick();
      #1;
      chk($sformatf("fill_valid%0d", k), 32'(valid_o), (32'h1 << k) - 32'h1);
      chk($sformatf("fill_en%0d", k), 32'(en_o), 32'h1f);
      chk($sformatf("fill_clear%0d", k), 32'(clear_o), 32'h00);
    end

    // Stall at stage 3
    stall_req_i = 5'b01000;
    #1;
    chk("stall_en", 32'(en_o), 32'h10);
    chk("stall_clear", 32'(clear_o), 32'h10);
    tick();
    stall_req_i = '0;
    #1;
    chk("stall_valid", 32'(valid_o), 32'h0f);
    chk("stall_refill_en", 32'(en_o), 32'h1f);
    chk("stall_refill_clear", 32'(clear_o), 32'h00);
    tick();
    chk("stall_refill_valid", 32'(valid_o), 32'h1f);

    // Flush beats stall
    flush_req_i = 5'b01000;
    stall_req_i = 5'b00010;
    #1;
    chk("flush_en", 32'(en_o), 32'h1f);
    chk("flush_clear", 32'(clear_o), 32'h0f);
    tick();
    flush_req_i = '0;
    stall_req_i = '0;
    #1;
    chk("flush_valid", 32'(valid_o), 32'h10);
    repeat (5) tick();
    chk("flush_refill_valid", 32'(valid_o), 32'h1f);

    // Multicycle, 3 cycles
    mc_start_i  = 1'b1;
    mc_cycles_i = 6'd3;
    #1;
    chk("mc_acc_en", 32'(en_o), 32'h18);
    chk("mc_acc_clear", 32'(clear_o), 32'h08);
    chk("mc_acc_busy", 32'(mc_busy_o), 32'h0);
    tick();
    mc_start_i = 1'b0;
    #1;
    chk("mc_b1_busy", 32'(mc_busy_o), 32'h1);
    chk("mc_b1_en", 32'(en_o), 32'h18);
    chk("mc_b1_done", 32'(mc_done_o), 32'h0);
    chk("mc_b1_valid", 32'(valid_o), 32'h17);
    tick();
    chk("mc_b2_busy", 32'(mc_busy_o), 32'h1);
    chk("mc_b2_en", 32'(en_o), 32'h18);
    chk("mc_b2_done", 32'(mc_done_o), 32'h0);
    tick();
    chk("mc_done", 32'(mc_done_o), 32'h1);
    chk("mc_done_en", 32'(en_o), 32'h1f);
    chk("mc_done_busy", 32'(mc_busy_o), 32'h0);
    chk("mc_done_valid", 32'(valid_o), 32'h07);
    tick();
    chk("mc_done_pulse", 32'(mc_done_o), 32'h0);
    chk("mc_post_valid", 32'(valid_o), 32'h0f);
    tick();
    chk("mc_post_valid2", 32'(valid_o), 32'h1f);

    // Zero-length multicycle is ignored
    mc_start_i  = 1'b1;
    mc_cycles_i = 6'd0;
    #1;
    chk("mc0_en", 32'(en_o), 32'h1f);
    chk("mc0_clear", 32'(clear_o), 32'h00);
    tick();
    mc_start_i = 1'b0;
    #1;
    chk("mc0_busy", 32'(mc_busy_o), 32'h0);
    tick();
    chk("mc0_done", 32'(mc_done_o), 32'h0);

    // Abort a 10-cycle operation
    mc_start_i  = 1'b1;
    mc_cycles_i = 6'd10;
    #1;
    chk("ab_acc_en", 32'(en_o), 32'h18);
    tick();
    mc_start_i = 1'b0;
    #1;
    chk("ab_b1_busy", 32'(mc_busy_o), 32'h1);
    tick();
    flush_req_i = 5'b01000;
    #1;
    chk("ab_clear", 32'(clear_o), 32'h0f);
    chk("ab_en", 32'(en_o), 32'h1f);
    tick();
    flush_req_i = '0;
    #1;
    chk("ab_busy", 32'(mc_busy_o), 32'h0);
    chk("ab_done", 32'(mc_done_o), 32'h0);
    chk("ab_valid", 32'(valid_o), 32'h00);
    tick();
    chk("ab_done2", 32'(mc_done_o), 32'h0);

    // Async reset mid-multicycle
    repeat (5) tick();
    chk("ar_fill_valid", 32'(valid_o), 32'h1f);
    mc_start_i  = 1'b1;
    mc_cycles_i = 6'd10;
    tick();
    mc_start_i = 1'b0;
    tick();
    chk("ar_pre_busy", 32'(mc_busy_o), 32'h1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("ar_valid", 32'(valid_o), 32'h00);
    chk("ar_busy", 32'(mc_busy_o), 32'h0);
    chk("ar_en", 32'(en_o), 32'h1f);
    chk("ar_clear", 32'(clear_o), 32'h1f);
    tick();
    rst_ni = 1'b1;
    #1;
    chk("ar_rel_en", 32'(en_o), 32'h1f);
    chk("ar_rel_clear", 32'(clear_o), 32'h00);
    repeat (5) tick();
    chk("ar_refill_valid", 32'(valid_o), 32'h1f);
    chk("ar_refill_busy", 32'(mc_busy_o), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
